// File: rtl/hash_table_bucket_mm_pkg.sv
// Shared types and helpers for the bucket hash table.
package hash_table_pkg;

   typedef enum logic [2:0] {
      CLEAR  = 3'd0,
      B_IDLE = 3'd1,
      B_WR   = 3'd2,
      P_IDLE = 3'd3,
      P_CMP  = 3'd4,
      P_EMIT = 3'd5
   } state_t;

   // Widest bucket the slot-select helper can handle.
   localparam int unsigned MAX_SLOTS = 32;
   localparam int unsigned IDX_W     = $clog2(MAX_SLOTS);

   // Default geometry.
   localparam int unsigned DEF_TUPLE_WIDTH    = 64;
   localparam int unsigned DEF_TUPLES_PER_ROW = 4;
   localparam int unsigned DEF_CNT_W          = $clog2(DEF_TUPLES_PER_ROW + 1);
   localparam int unsigned DEF_ROW_WIDTH      = DEF_TUPLES_PER_ROW * DEF_TUPLE_WIDTH + DEF_CNT_W;

   function automatic int unsigned cnt_width(input int unsigned slots);
      return $clog2(slots + 1);
   endfunction

   function automatic int unsigned row_width(input int unsigned tuple_w, input int unsigned slots);
      return slots * tuple_w + cnt_width(slots);
   endfunction

   // Index of the lowest set bit; 0 when the mask is empty.
   function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_SLOTS-1:0] mask);
      logic              found;
      logic [IDX_W-1:0]  idx;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < MAX_SLOTS; i++) begin
         if (mask[i] && !found) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/hash_table_bucket_mm_match.sv
// Combinational key compare across all occupied slots of one bucket.
module bucket_match_unit
   import hash_table_pkg::*;
#(
   parameter int unsigned TUPLE_WIDTH    = DEF_TUPLE_WIDTH,
   parameter int unsigned KEY_WIDTH      = 32,
   parameter int unsigned TUPLES_PER_ROW = DEF_TUPLES_PER_ROW,
   parameter int unsigned CNT_W          = $clog2(TUPLES_PER_ROW + 1)
) (
   input  logic [TUPLES_PER_ROW*TUPLE_WIDTH-1:0] slots,
   input  logic [CNT_W-1:0]                      count,
   input  logic [KEY_WIDTH-1:0]                  key,
   output logic [TUPLES_PER_ROW-1:0]             mask
);

   // Slots at or above the fill count hold stale data and never match.
   always_comb begin
      mask = '0;
      for (int unsigned s = 0; s < TUPLES_PER_ROW; s++) begin
         mask[s] = (CNT_W'(s) < count) &&
                   (slots[s*TUPLE_WIDTH +: KEY_WIDTH] == key);
      end
   end

endmodule

// File: rtl/hash_table_bucket_mm_ram.sv
// Simple dual-port RAM, one write port, one read port, registered read.
module simple_dual_port_ram_single_clock #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] q
);

   logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

   // Write and read-before-write registered read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      q <= mem[raddr];
   end

endmodule

// File: rtl/hash_table_bucket_mm.sv
// Bucket hash table for one join partition: clear, build, probe with multi-match output.
module hash_table_bucket_mm
   import hash_table_pkg::*;
#(
   parameter int unsigned TUPLE_WIDTH    = 64,
   parameter int unsigned KEY_WIDTH      = 32,
   parameter int unsigned ROW_BITS       = 3,
   parameter int unsigned TUPLES_PER_ROW = 4,
   parameter int unsigned CNT_W          = $clog2(TUPLES_PER_ROW + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_build_valid,
   output logic                     in_build_ready,
   input  logic [TUPLE_WIDTH-1:0]   in_build_data,
   input  logic [31:0]              in_build_hash,
   input  logic                     in_build_last,
   input  logic                     in_probe_valid,
   output logic                     in_probe_ready,
   input  logic [TUPLE_WIDTH-1:0]   in_probe_data,
   input  logic [31:0]              in_probe_hash,
   input  logic [63:0]              in_probe_serialnum,
   input  logic                     in_probe_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*TUPLE_WIDTH-1:0] out_data,
   output logic [63:0]              out_serialnum,
   output logic                     out_was_joined,
   output logic                     out_last,
   output logic                     overflow,
   output logic [31:0]              drop_count
);

   localparam int unsigned NUM_ROWS  = 1 << ROW_BITS;
   localparam int unsigned SLOT_BITS = TUPLES_PER_ROW * TUPLE_WIDTH;
   localparam int unsigned ROW_WIDTH = SLOT_BITS + CNT_W;
   localparam logic [CNT_W-1:0]    FULL     = CNT_W'(TUPLES_PER_ROW);
   localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(NUM_ROWS - 1);

   state_t                     state;
   logic [ROW_BITS-1:0]        clr_idx;
   logic [ROW_BITS-1:0]        build_row;
   logic [TUPLE_WIDTH-1:0]     build_data;
   logic                       build_last_q;
   logic [TUPLE_WIDTH-1:0]     probe_data;
   logic [63:0]                probe_serial;
   logic                       probe_last_q;
   logic [TUPLES_PER_ROW-1:0]  mask_q;
   logic                       hit_q;
   logic [SLOT_BITS-1:0]       slots_q;

   logic                       we;
   logic [ROW_BITS-1:0]        waddr;
   logic [ROW_BITS-1:0]        raddr;
   logic [ROW_WIDTH-1:0]       wdata;
   logic [ROW_WIDTH-1:0]       q;
   logic [CNT_W-1:0]           rd_count;
   logic [SLOT_BITS-1:0]       rd_slots;
   logic [TUPLES_PER_ROW-1:0]  mask_now;

   logic [IDX_W-1:0]           beat_idx;
   logic [TUPLES_PER_ROW-1:0]  mask_rest;
   logic                       final_beat;
   logic [TUPLE_WIDTH-1:0]     beat_build;

   logic                       unused_hash_bits;

   assign unused_hash_bits = ^{in_build_hash[31:ROW_BITS], in_probe_hash[31:ROW_BITS]};

   assign rd_count = q[ROW_WIDTH-1 -: CNT_W];
   assign rd_slots = q[SLOT_BITS-1:0];

   // Reads are only meaningful in B_IDLE (build hash) and P_IDLE (probe hash).
   assign raddr = (state == B_IDLE) ? in_build_hash[ROW_BITS-1:0]
                                    : in_probe_hash[ROW_BITS-1:0];

   simple_dual_port_ram_single_clock #(
      .DATA_WIDTH (ROW_WIDTH),
      .ADDR_WIDTH (ROW_BITS)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .q     (q)
   );

   bucket_match_unit #(
      .TUPLE_WIDTH    (TUPLE_WIDTH),
      .KEY_WIDTH      (KEY_WIDTH),
      .TUPLES_PER_ROW (TUPLES_PER_ROW),
      .CNT_W          (CNT_W)
   ) u_match (
      .slots (rd_slots),
      .count (rd_count),
      .key   (probe_data[KEY_WIDTH-1:0]),
      .mask  (mask_now)
   );

   // RAM write port: zero rows while clearing, slot insert plus count bump in B_WR.
   always_comb begin
      we    = 1'b0;
      waddr = build_row;
      wdata = q;
      if (state == CLEAR) begin
         we    = 1'b1;
         waddr = clr_idx;
         wdata = '0;
      end else if (state == B_WR && rd_count < FULL) begin
         we = 1'b1;
         for (int unsigned s = 0; s < TUPLES_PER_ROW; s++) begin
            if (CNT_W'(s) == rd_count) begin
               wdata[s*TUPLE_WIDTH +: TUPLE_WIDTH] = build_data;
            end
         end
         wdata[ROW_WIDTH-1 -: CNT_W] = rd_count + CNT_W'(1);
      end
   end

   // Current emit beat: lowest remaining match slot, and whether it is the last one.
   always_comb begin
      beat_idx   = lowest_set(MAX_SLOTS'(mask_q));
      mask_rest  = mask_q;
      beat_build = '0;
      for (int unsigned s = 0; s < TUPLES_PER_ROW; s++) begin
         if (IDX_W'(s) == beat_idx) begin
            mask_rest[s] = 1'b0;
            beat_build   = slots_q[s*TUPLE_WIDTH +: TUPLE_WIDTH];
         end
      end
      final_beat = !hit_q || (mask_rest == '0);
   end

   // Outputs decode from state so everything is zero outside P_EMIT and stable under backpressure.
   always_comb begin
      in_build_ready = (state == B_IDLE);
      in_probe_ready = (state == P_IDLE);
      out_valid      = (state == P_EMIT);
      out_data       = '0;
      out_serialnum  = '0;
      out_was_joined = 1'b0;
      out_last       = 1'b0;
      if (state == P_EMIT) begin
         out_data       = {(hit_q ? beat_build : {TUPLE_WIDTH{1'b0}}), probe_data};
         out_serialnum  = probe_serial;
         out_was_joined = hit_q;
         out_last       = final_beat && probe_last_q;
      end
   end

   // Control FSM and captured tuple state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= CLEAR;
         clr_idx      <= '0;
         build_row    <= '0;
         build_data   <= '0;
         build_last_q <= 1'b0;
         probe_data   <= '0;
         probe_serial <= '0;
         probe_last_q <= 1'b0;
         mask_q       <= '0;
         hit_q        <= 1'b0;
         slots_q      <= '0;
         overflow     <= 1'b0;
         drop_count   <= '0;
      end else begin
         case (state)
            CLEAR: begin
               clr_idx <= clr_idx + ROW_BITS'(1);
               if (clr_idx == LAST_ROW) begin
                  state <= B_IDLE;
               end
            end
            B_IDLE: begin
               if (in_build_valid) begin
                  build_data   <= in_build_data;
                  build_row    <= in_build_hash[ROW_BITS-1:0];
                  build_last_q <= in_build_last;
                  state        <= B_WR;
               end else if (in_build_last) begin
                  state <= P_IDLE;
               end
            end
            B_WR: begin
               if (rd_count >= FULL) begin
                  overflow <= 1'b1;
                  if (drop_count != '1) begin
                     drop_count <= drop_count + 32'd1;
                  end
               end
               state <= build_last_q ? P_IDLE : B_IDLE;
            end
            P_IDLE: begin
               if (in_probe_valid) begin
                  probe_data   <= in_probe_data;
                  probe_serial <= in_probe_serialnum;
                  probe_last_q <= in_probe_last;
                  state        <= P_CMP;
               end
            end
            P_CMP: begin
               mask_q  <= mask_now;
               hit_q   <= |mask_now;
               slots_q <= rd_slots;
               state   <= P_EMIT;
            end
            P_EMIT: begin
               if (out_ready) begin
                  if (final_beat) begin
                     if (probe_last_q) begin
                        state      <= CLEAR;
                        clr_idx    <= '0;
                        overflow   <= 1'b0;
                        drop_count <= '0;
                     end else begin
                        state <= P_IDLE;
                     end
                  end else begin
                     mask_q <= mask_rest;
                  end
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_hash_table_bucket_mm.sv
// Directed, table-driven bench for hash_table_bucket_mm at default geometry.
module tb_hash_table_bucket_mm;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_build_valid, in_build_ready, in_build_last;
   logic [63:0]  in_build_data;
   logic [31:0]  in_build_hash;
   logic         in_probe_valid, in_probe_ready, in_probe_last;
   logic [63:0]  in_probe_data;
   logic [31:0]  in_probe_hash;
   logic [63:0]  in_probe_serialnum;
   logic         out_valid, out_ready, out_was_joined, out_last, overflow;
   logic [127:0] out_data;
   logic [63:0]  out_serialnum;
   logic [31:0]  drop_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [31:0] key;
      logic [31:0] tag;
      logic [31:0] hash;
      logic        last;
   } bvec_t;

   typedef struct packed {
      logic [31:0]       key;
      logic [31:0]       hash;
      logic [63:0]       serial;
      logic              last;
      logic [3:0]        hold;
      logic [2:0]        nbeats;
      logic              joined;
      logic [0:3][31:0]  tags;
   } pvec_t;

   bvec_t bv[12];
   pvec_t pv[9];

   hash_table_bucket_mm #(
      .TUPLE_WIDTH    (64),
      .KEY_WIDTH      (32),
      .ROW_BITS       (3),
      .TUPLES_PER_ROW (4)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .in_build_valid     (in_build_valid),
      .in_build_ready     (in_build_ready),
      .in_build_data      (in_build_data),
      .in_build_hash      (in_build_hash),
      .in_build_last      (in_build_last),
      .in_probe_valid     (in_probe_valid),
      .in_probe_ready     (in_probe_ready),
      .in_probe_data      (in_probe_data),
      .in_probe_hash      (in_probe_hash),
      .in_probe_serialnum (in_probe_serialnum),
      .in_probe_last      (in_probe_last),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_data           (out_data),
      .out_serialnum      (out_serialnum),
      .out_was_joined     (out_was_joined),
      .out_last           (out_last),
      .overflow           (overflow),
      .drop_count         (drop_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bvec_t mkb(input logic [31:0] key, tag, hash, input logic last);
      bvec_t b;
      b.key = key; b.tag = tag; b.hash = hash; b.last = last;
      return b;
   endfunction

   function automatic pvec_t mkp(input logic [31:0] key, hash, input logic [63:0] serial,
                                 input logic last, input logic [3:0] hold, input logic [2:0] nbeats,
                                 input logic joined, input logic [0:3][31:0] tags);
      pvec_t p;
      p.key = key; p.hash = hash; p.serial = serial; p.last = last;
      p.hold = hold; p.nbeats = nbeats; p.joined = joined; p.tags = tags;
      return p;
   endfunction

   // Counts negedges until the table leaves CLEAR; expected to be the row count.
   task automatic check_clear_len(input string name);
      int unsigned n;
      n = 0;
      while (!in_build_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(name, 128'(n), 128'd8);
   endtask

   task automatic do_build(input bvec_t b);
      int unsigned t;
      in_build_valid = 1'b1;
      in_build_data  = {b.tag, b.key};
      in_build_hash  = b.hash;
      in_build_last  = b.last;
      t = 0;
      while (!in_build_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_build_ready) chk("build_ready_timeout", 128'(in_build_ready), 128'd1);
      @(posedge clk);
      #1;
      in_build_valid = 1'b0;
      in_build_last  = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_probe(input pvec_t v, input int unsigned idx);
      int unsigned t;
      logic [63:0]  ptuple;
      logic [63:0]  exp_build;
      logic [193:0] snap;
      ptuple             = {32'hEE00_0000 | 32'(idx), v.key};
      out_ready          = (v.hold == 0);
      in_probe_valid     = 1'b1;
      in_probe_data      = ptuple;
      in_probe_hash      = v.hash;
      in_probe_serialnum = v.serial;
      in_probe_last      = v.last;
      t = 0;
      while (!in_probe_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_probe_ready) chk("probe_ready_timeout", 128'(in_probe_ready), 128'd1);
      @(posedge clk);
      #1;
      in_probe_valid = 1'b0;
      in_probe_last  = 1'b0;
      @(negedge clk);
      for (int unsigned b = 0; b < 32'(v.nbeats); b++) begin
         t = 0;
         while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
         end
         chk($sformatf("p%0d_b%0d_valid", idx, b), 128'(out_valid), 128'd1);
         if (b == 0 && v.hold != 0) begin
            snap = {out_data, out_serialnum, out_was_joined, out_last};
            for (int unsigned h = 0; h < 32'(v.hold); h++) begin
               @(negedge clk);
               chk($sformatf("p%0d_hold%0d_stable", idx, h),
                   128'({out_valid, out_data, out_serialnum, out_was_joined, out_last} != {1'b1, snap}),
                   128'd0);
               chk($sformatf("p%0d_hold%0d_pready", idx, h), 128'(in_probe_ready), 128'd0);
            end
            out_ready = 1'b1;
         end
         exp_build = v.joined ? {v.tags[b], v.key} : 64'd0;
         chk($sformatf("p%0d_b%0d_data", idx, b), out_data, {exp_build, ptuple});
         chk($sformatf("p%0d_b%0d_joined", idx, b), 128'(out_was_joined), 128'(v.joined));
         chk($sformatf("p%0d_b%0d_serial", idx, b), 128'(out_serialnum), 128'(v.serial));
         chk($sformatf("p%0d_b%0d_last", idx, b), 128'(out_last),
             128'(v.last && (b == 32'(v.nbeats) - 1)));
         @(posedge clk);
         @(negedge clk);
      end
      chk($sformatf("p%0d_no_extra_beat", idx), 128'(out_valid), 128'd0);
   endtask

   initial begin
      // Build side: row 0 filled with key 3, key 5 in row 1, key 9 in row 3,
      // six key-11 tuples into row 2 (two dropped); upper hash bits vary.
      for (int unsigned i = 0; i < 4; i++) bv[i] = mkb(32'd3, 32'h30 + 32'(i), 32'h0, 1'b0);
      bv[4] = mkb(32'd5, 32'h50, 32'h1, 1'b0);
      bv[5] = mkb(32'd9, 32'h90, 32'h3, 1'b0);
      for (int unsigned i = 0; i < 6; i++)
         bv[6+i] = mkb(32'd11, 32'hB0 + 32'(i), (i % 2 == 0) ? 32'h2 : 32'h1A, i == 5);

      pv[0] = mkp(32'd5,  32'h1,  64'd7,     1'b0, 4'd0, 3'd1, 1'b1, {32'h50, 32'h0, 32'h0, 32'h0});
      pv[1] = mkp(32'd3,  32'h0,  64'h100,   1'b0, 4'd5, 3'd4, 1'b1, {32'h30, 32'h31, 32'h32, 32'h33});
      pv[2] = mkp(32'd11, 32'h2,  64'h200,   1'b0, 4'd0, 3'd4, 1'b1, {32'hB0, 32'hB1, 32'hB2, 32'hB3});
      pv[3] = mkp(32'd77, 32'h5,  64'h300,   1'b0, 4'd0, 3'd1, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0});
      pv[4] = mkp(32'd0,  32'h4,  64'h301,   1'b0, 4'd0, 3'd1, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0});
      pv[5] = mkp(32'd0,  32'h1,  64'h302,   1'b0, 4'd0, 3'd1, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0});
      pv[6] = mkp(32'd9,  32'hF3, 64'h303,   1'b0, 4'd0, 3'd1, 1'b1, {32'h90, 32'h0, 32'h0, 32'h0});
      pv[7] = mkp(32'd11, 32'h1A, 64'h304,   1'b0, 4'd0, 3'd4, 1'b1, {32'hB0, 32'hB1, 32'hB2, 32'hB3});
      pv[8] = mkp(32'd3,  32'h0,  64'h305,   1'b1, 4'd0, 3'd4, 1'b1, {32'h30, 32'h31, 32'h32, 32'h33});

      reset = 1'b1;
      in_build_valid = 1'b0; in_build_data = '0; in_build_hash = '0; in_build_last = 1'b0;
      in_probe_valid = 1'b0; in_probe_data = '0; in_probe_hash = '0;
      in_probe_serialnum = '0; in_probe_last = 1'b0;
      out_ready = 1'b1;

      #3;
      chk("rst_build_ready", 128'(in_build_ready), 128'd0);
      chk("rst_probe_ready", 128'(in_probe_ready), 128'd0);
      chk("rst_out_valid",   128'(out_valid), 128'd0);
      chk("rst_out_data",    out_data, 128'd0);
      chk("rst_out_misc",    128'({out_serialnum, out_was_joined, out_last}), 128'd0);
      chk("rst_overflow",    128'(overflow), 128'd0);
      chk("rst_drop_count",  128'(drop_count), 128'd0);

      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_clear_len("clear_len_initial");

      for (int unsigned i = 0; i < 12; i++) do_build(bv[i]);
      @(negedge clk);
      chk("build_probe_ready", 128'(in_probe_ready), 128'd1);
      chk("build_overflow",    128'(overflow), 128'd1);
      chk("build_drop_count",  128'(drop_count), 128'd2);

      for (int unsigned i = 0; i < 9; i++) do_probe(pv[i], i);

      // Final probe carried last: table is clearing again with counters reset.
      chk("reclear_overflow",   128'(overflow), 128'd0);
      chk("reclear_drop_count", 128'(drop_count), 128'd0);
      chk("reclear_readys",     128'({in_build_ready, in_probe_ready}), 128'd0);
      check_clear_len("clear_len_after_last");

      // Reset while a match beat is held by backpressure.
      do_build(mkb(32'd21, 32'h2100, 32'h6, 1'b1));
      out_ready          = 1'b0;
      in_probe_valid     = 1'b1;
      in_probe_data      = {32'hEE00_00AA, 32'd21};
      in_probe_hash      = 32'h6;
      in_probe_serialnum = 64'h999;
      in_probe_last      = 1'b0;
      begin
         int unsigned t;
         t = 0;
         while (!in_probe_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         @(posedge clk);
         #1;
         in_probe_valid = 1'b0;
         t = 0;
         while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
         end
      end
      chk("pre_abort_valid",  128'(out_valid), 128'd1);
      chk("pre_abort_joined", 128'(out_was_joined), 128'd1);
      reset = 1'b1;
      #1;
      chk("abort_out_valid", 128'(out_valid), 128'd0);
      chk("abort_out_data",  out_data, 128'd0);
      chk("abort_out_misc",  128'({out_serialnum, out_was_joined, out_last}), 128'd0);
      chk("abort_readys",    128'({in_build_ready, in_probe_ready}), 128'd0);
      out_ready = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_clear_len("clear_len_after_abort");

      // Empty build: last without valid goes straight to probing.
      in_build_last = 1'b1;
      @(posedge clk);
      #1;
      in_build_last = 1'b0;
      @(negedge clk);
      chk("empty_build_readys", 128'({in_build_ready, in_probe_ready}), 128'd1);
      do_probe(mkp(32'd21, 32'h6, 64'h555, 1'b0, 4'd0, 3'd1, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0}), 20);
      do_probe(mkp(32'd5,  32'h1, 64'h556, 1'b1, 4'd0, 3'd1, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0}), 21);
      chk("final_clear_readys", 128'({in_build_ready, in_probe_ready}), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hash_table_bucket_mm.md
Name: hash_table_bucket_mm

Overview:
Parametrised bucket hash table for one partition of the partitioned hash join.
- Build phase: clears all rows, then inserts build tuples into fixed-depth buckets, with overflow detection.
- Probe phase: looks up probe tuples and emits one output beat per matching build tuple (multi-match), or one unmatched beat.
- Returns automatically to clearing after the last probe tuple, ready for the next partition.

Parameters:
TUPLE_WIDTH, 64, bits per tuple; the key is the low KEY_WIDTH bits
KEY_WIDTH, 32, compared key bits
ROW_BITS, 3, log2 of row count; NUM_ROWS = 2**ROW_BITS
TUPLES_PER_ROW, 4, bucket depth in slots (>=1)
CNT_W, $clog2(TUPLES_PER_ROW+1), per-row fill-count width (derived)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_build_valid  in  1  build tuple valid
in_build_ready  out  1  build tuple accepted when valid&ready
in_build_data  in  TUPLE_WIDTH  build tuple
in_build_hash  in  32  hash; low ROW_BITS select the row
in_build_last  in  1  end of build side (may arrive with or without valid)
in_probe_valid  in  1  probe tuple valid
in_probe_ready  out  1  probe handshake
in_probe_data  in  TUPLE_WIDTH  probe tuple
in_probe_hash  in  32  hash
in_probe_serialnum  in  64  tag carried to the output
in_probe_last  in  1  marks the final probe tuple (only with valid)
out_valid  out  1  result valid
out_ready  in  1  downstream ready
out_data  out  2*TUPLE_WIDTH  {build tuple, probe tuple}; build half is 0 when unmatched
out_serialnum  out  64  serialnum of the probe tuple
out_was_joined  out  1  1 = match beat, 0 = no-match beat
out_last  out  1  final beat of the last probe tuple
overflow  out  1  sticky: at least one build tuple was dropped
drop_count  out  32  dropped build tuples, saturating

Behaviour:
- Reset:
  - State is CLEAR, row index 0.
  - All outputs are 0: both readys, out_* fields, overflow, drop_count.
  - Reset asserted mid-operation aborts everything. RAM contents are don't-care; CLEAR rewrites them.
- Row format: slot s occupies bits [s*TUPLE_WIDTH +: TUPLE_WIDTH]; the count sits above the slots. Slots fill from slot 0 upward.
- CLEAR: writes a zero row per cycle for NUM_ROWS cycles, both readys held 0, then moves to B_IDLE. drop_count and overflow clear on entry to CLEAR.
- B_IDLE:
  - in_build_ready = 1.
  - On a handshake, drive raddr from the hash, capture data and row, go to B_WR.
  - in_build_last without valid goes to P_IDLE.
  - last together with valid: insert the tuple, then go to P_IDLE from B_WR.
- B_WR:
  - If count < TUPLES_PER_ROW: write the tuple into slot[count] and write count+1.
  - Otherwise: no write, set overflow, drop_count += 1 (saturating at 2^32-1).
  - Throughput is one build tuple per 2 cycles. The next read always follows the write by at least one cycle, so no forwarding is needed.
- P_IDLE:
  - in_probe_ready = 1.
  - On a handshake, issue the read and capture data, serialnum and last, then go to P_CMP.
  - Build inputs are ignored; in_build_ready = 0.
- P_CMP (1 cycle after the read):
  - Register the match mask: mask[s] = (s < count) & (slot key == probe key). Register the row.
  - Go to P_EMIT.
- P_EMIT:
  - Present one beat per set mask bit, lowest slot first. Advance only on out_valid & out_ready.
  - mask == 0: one beat with out_was_joined = 0.
  - The first beat is valid 2 cycles after the probe handshake.
  - All out_* fields stay stable while out_valid & ~out_ready.
  - After the final beat: go to P_IDLE, or to CLEAR if captured last = 1.
- out_last = 1 only on the final beat of a tuple whose in_probe_last was 1.
- Keys compare on KEY_WIDTH bits only; hash bits above ROW_BITS are ignored.
- Readys are 0 in CLEAR, B_WR, P_CMP and P_EMIT.

Decomposition:
- Package hash_table_pkg holds:
  - the state enum (CLEAR, B_IDLE, B_WR, P_IDLE, P_CMP, P_EMIT);
  - row-width and CNT_W localparams;
  - a function for the lowest set bit of the mask.
- RAM instance: simple_dual_port_ram_single_clock, 1-cycle registered read.
- Natural sub-module: bucket_match_unit, combinational; takes row, count and key, returns the match mask.

Test Plan:
- Reset, then build keys 5 (hash 1) and 9 (hash 2), build_last, probe key 5 hash 1 serial 7 -> one beat: out_data = {tuple5, probe5}, was_joined = 1, serial 7.
- Build 4 tuples with key 3 in row 0 (TUPLES_PER_ROW=4), probe key 3 -> 4 beats, slots 0..3 in order; out_last only on beat 4 when that probe has last = 1.
- Build 6 tuples into row 2 -> overflow = 1, drop_count = 2; probe returns 4 matches.
- Probe key 77 absent -> single beat, was_joined = 0, build half 0; probe key matching an empty slot's stale zero -> no match.
- Hold out_ready = 0 for 5 cycles mid-emit -> outputs stable, in_probe_ready = 0, no beats lost.
- Assert reset during P_EMIT, then rebuild -> outputs 0 immediately; CLEAR takes NUM_ROWS cycles; old contents never match.
